// File: rtl/load_store_unit_pkg.sv
// Shared constants and types for the load/store unit and its store buffer.
package lsu_pkg;

    localparam int unsigned DATA_BYTES_DEFAULT = 128;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_RANGE    = 2'b10;
    localparam logic [1:0] CAUSE_FUNC3    = 2'b11;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } lsu_state_t;

    function automatic logic [2:0] access_size(input logic [1:0] size_code);
        case (size_code)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_store_buffer.sv
// FIFO of pending stores with per-entry byte-range overlap detection for loads.
module store_buffer
    import lsu_pkg::*;
#(
    parameter int unsigned SB_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [6:0]  push_addr,
    input  logic [31:0] push_data,
    input  logic [2:0]  push_func3,
    input  logic        pop,
    input  logic [6:0]  chk_addr,
    input  logic [2:0]  chk_size,
    output logic [6:0]  head_addr,
    output logic [31:0] head_data,
    output logic [2:0]  head_func3,
    output logic        full,
    output logic        empty,
    output logic        conflict
);

    localparam int unsigned PW = $clog2(SB_DEPTH);
    localparam int unsigned CW = $clog2(SB_DEPTH) + 1;

    logic [6:0]    ent_addr  [SB_DEPTH];
    logic [31:0]   ent_data  [SB_DEPTH];
    logic [2:0]    ent_func3 [SB_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(SB_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head_addr  = ent_addr[rd_ptr];
    assign head_data  = ent_data[rd_ptr];
    assign head_func3 = ent_func3[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            ent_addr[wr_ptr]  <= push_addr;
            ent_data[wr_ptr]  <= push_data;
            ent_func3[wr_ptr] <= push_func3;
        end
    end

    // Walk the occupied slots from the head; ranges are half-open [lo, hi).
    always_comb begin
        logic [PW-1:0] slot;
        logic [7:0]    c_lo, c_hi, e_lo, e_hi;
        conflict = 1'b0;
        slot     = '0;
        e_lo     = '0;
        e_hi     = '0;
        c_lo     = {1'b0, chk_addr};
        c_hi     = c_lo + 8'(chk_size);
        for (int unsigned k = 0; k < SB_DEPTH; k++) begin
            slot = rd_ptr + PW'(k);
            e_lo = {1'b0, ent_addr[slot]};
            e_hi = e_lo + 8'(access_size(ent_func3[slot][1:0]));
            if ((CW'(k) < count) && (c_lo < e_hi) && (e_lo < c_hi))
                conflict = 1'b1;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: fault checks, store buffering, load issue and fence drain.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned SB_DEPTH   = 2,
    parameter int unsigned DATA_BYTES = DATA_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_func3,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr,
    output logic [13:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic [2:0]  mem_func3,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_data_out
);

    lsu_state_t  state, state_next;
    logic        is_load, is_store, req_mem;
    logic [2:0]  acc_sz;
    logic        bad_func3, misaligned, out_of_range;
    logic [1:0]  fault_cause;
    logic        running, load_ok, store_ok, fault_take;
    logic        load_issue, drain, store_stall, stall_int, sb_push;
    logic [6:0]  head_addr;
    logic [31:0] head_data;
    logic [2:0]  head_func3;
    logic        sb_full, sb_empty, sb_conflict;

    always_comb begin
        is_load  = req_read;
        is_store = req_write && !req_read;
        req_mem  = req_valid && (is_load || is_store);
        acc_sz   = access_size(req_func3[1:0]);
        if (is_load)
            bad_func3 = !(req_func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        else
            bad_func3 = !(req_func3 inside {F3_B, F3_H, F3_W});
        misaligned   = ((req_func3[1:0] == 2'b01) && req_addr[0])
                    || ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = (({1'b0, req_addr} + 33'(acc_sz)) > 33'(DATA_BYTES));
        if (bad_func3)         fault_cause = CAUSE_FUNC3;
        else if (misaligned)   fault_cause = CAUSE_MISALIGN;
        else if (out_of_range) fault_cause = CAUSE_RANGE;
        else                   fault_cause = CAUSE_NONE;
    end

    // A store only stalls when full and the head cannot leave this cycle;
    // a conflicting load is not issued, which lets the head drain meanwhile.
    always_comb begin
        running     = (state == ST_RUN);
        fault_take  = running && req_mem && (fault_cause != CAUSE_NONE);
        load_ok     = running && req_mem && is_load  && (fault_cause == CAUSE_NONE);
        store_ok    = running && req_mem && is_store && (fault_cause == CAUSE_NONE);
        load_issue  = load_ok && !sb_conflict;
        drain       = !sb_empty && !load_issue;
        store_stall = store_ok && sb_full && !drain;
        sb_push     = store_ok && !store_stall;
        stall_int   = !running || (load_ok && sb_conflict) || store_stall;
    end

    assign stall = rst_n && stall_int;

    store_buffer #(
        .SB_DEPTH (SB_DEPTH)
    ) u_store_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (sb_push),
        .push_addr  (req_addr[6:0]),
        .push_data  (req_wdata),
        .push_func3 (req_func3),
        .pop        (drain),
        .chk_addr   (req_addr[6:0]),
        .chk_size   (acc_sz),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .head_func3 (head_func3),
        .full       (sb_full),
        .empty      (sb_empty),
        .conflict   (sb_conflict)
    );

    always_comb begin
        mem_addr    = '0;
        mem_data_in = '0;
        mem_func3   = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        if (rst_n) begin
            if (load_issue) begin
                mem_read  = 1'b1;
                mem_addr  = {req_addr[6:0], 7'b0};
                mem_func3 = req_func3;
            end else if (drain) begin
                mem_write   = 1'b1;
                mem_addr    = {head_addr, 7'b0};
                mem_data_in = head_data;
                mem_func3   = head_func3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:   if (flush && !sb_empty) state_next = ST_FLUSH;
            ST_FLUSH: if (sb_empty)           state_next = ST_RUN;
            default:                          state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_valid <= 1'b0;
            load_data  <= '0;
            exc_valid  <= 1'b0;
            exc_cause  <= '0;
            exc_addr   <= '0;
        end else begin
            load_valid <= load_issue;
            if (load_issue) load_data <= mem_data_out;
            exc_valid <= fault_take;
            if (fault_take) begin
                exc_cause <= fault_cause;
                exc_addr  <= req_addr;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit against a program-order byte-memory model.
module tb_load_store_unit;

    localparam int DB = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_read, req_write, flush;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_func3;
    logic        stall, load_valid, exc_valid, mem_read, mem_write;
    logic [31:0] load_data, exc_addr, mem_data_in, mem_data_out;
    logic [1:0]  exc_cause;
    logic [13:0] mem_addr;
    logic [2:0]  mem_func3;

    always #5 clk = ~clk;

    load_store_unit #(
        .SB_DEPTH   (2),
        .DATA_BYTES (DB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_read     (req_read),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_func3    (req_func3),
        .flush        (flush),
        .stall        (stall),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .exc_valid    (exc_valid),
        .exc_cause    (exc_cause),
        .exc_addr     (exc_addr),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_func3    (mem_func3),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_data_out (mem_data_out)
    );

    logic [7:0]  dmem    [DB];   // data RAM behind the memory port
    logic [7:0]  ref_mem [DB];   // architectural memory in program order
    logic [7:0]  snap    [DB];
    logic [31:0] load_q  [$];
    logic [33:0] exc_q   [$];
    int          checks = 0;
    int          errors = 0;
    bit          mem_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
        case (f3)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b100:  return {24'b0, raw[7:0]};
            3'b101:  return {16'b0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    always @(posedge clk) begin : env_write
        int a, n;
        if (!mem_ready) begin
            for (int i = 0; i < DB; i++) dmem[i] <= 8'(i * 37 + 5);
            mem_ready <= 1'b1;
        end else if (mem_write) begin
            a = int'(mem_addr[13:7]);
            n = 1 << mem_func3[1:0];
            for (int i = 0; i < n; i++) dmem[(a + i) % DB] <= mem_data_in[8*i +: 8];
        end
    end

    always_comb begin
        int a;
        a = int'(mem_addr[13:7]);
        mem_data_out = extend({dmem[(a + 3) % DB], dmem[(a + 2) % DB],
                               dmem[(a + 1) % DB], dmem[a]}, mem_func3);
    end

    function automatic logic [1:0] ref_cause(input logic rd, input logic [31:0] a, input logic [2:0] f3);
        longint unsigned sz;
        if (rd ? !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : !(f3 inside {3'd0, 3'd1, 3'd2}))
            return 2'b11;
        sz = 64'd1 << f3[1:0];
        if ((longint'(a) % sz) != 0) return 2'b01;
        if (longint'(a) + sz > DB) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ref_load(input int a, input logic [2:0] f3);
        return extend({ref_mem[(a + 3) % DB], ref_mem[(a + 2) % DB],
                       ref_mem[(a + 1) % DB], ref_mem[a]}, f3);
    endfunction

    // Monitor: every registered response is matched against the oldest expectation.
    always @(negedge clk) begin
        logic [31:0] el;
        logic [33:0] ee;
        if (!rst_n) begin
            check("write_in_reset", mem_write, 0);
        end else begin
            if (load_valid) begin
                if (load_q.size() == 0) check("load_unexpected", load_data, 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    el = load_q.pop_front();
                    check("load_data", load_data, el);
                end
            end
            if (exc_valid) begin
                if (exc_q.size() == 0) check("exc_unexpected", {exc_cause, exc_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    ee = exc_q.pop_front();
                    check("exc_cause_addr", {exc_cause, exc_addr}, ee);
                end
            end
        end
    end

    task automatic idle(input int n);
        req_valid = 1'b0;
        flush     = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the request is taken.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, input logic fl, input logic nowr, output int stalls);
        logic [1:0] cause;
        int         sz;
        req_valid = 1'b1;
        req_read  = rd;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        req_func3 = f3;
        flush     = fl;
        stalls    = 0;
        @(negedge clk);
        while (stall && stalls <= 20) begin
            stalls++;
            @(posedge clk);
            #1;
            flush = 1'b0;
            @(negedge clk);
        end
        if (stall) begin
            check("stall_timeout", 1, 0);
        end else begin
            cause = ref_cause(rd, a, f3);
            if (cause != 2'b00) begin
                exc_q.push_back({cause, a});
                check("fault_no_read", mem_read, 0);
                if (nowr) check("fault_no_write", mem_write, 0);
            end else if (rd) begin
                load_q.push_back(ref_load(int'(a[6:0]), f3));
                check("load_issue", {mem_read, mem_addr, mem_func3}, {1'b1, a[6:0], 7'b0, f3});
            end else if (wr) begin
                sz = 1 << f3[1:0];
                for (int i = 0; i < sz; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
                check("store_no_read", mem_read, 0);
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          st, n, sel, sz, nmis;
        logic        rd, wr, fl;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [2:0]  ld_f3 [5];
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < DB; i++) ref_mem[i] = 8'(i * 37 + 5);
        rst_n = 1'b0; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; req_func3 = '0; flush = 1'b0;
        @(negedge clk);
        check("reset_outputs", {stall, load_valid, exc_valid, load_data, exc_cause, exc_addr, mem_read, mem_write}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // store then independent load: no stall, 1-cycle latency, store drains afterwards
        issue(0, 1, 32'h10, 32'h1122_3344, 3'b010, 0, 0, st);
        check("sw_nostall", st, 0);
        issue(1, 0, 32'h20, 0, 3'b010, 0, 0, st);
        check("lw_nostall", st, 0);
        @(negedge clk);
        check("lw_latency", load_valid, 1);
        check("drain_after_load", {mem_write, mem_addr, mem_data_in}, {1'b1, 7'h10, 7'b0, 32'h1122_3344});
        @(posedge clk); #1;

        // overlapping byte load waits for the store, returns sign-extended 0xB6
        idle(3);
        issue(0, 1, 32'h08, 32'hA5B6_C7D8, 3'b010, 0, 0, st);
        issue(1, 0, 32'h0A, 0, 3'b000, 0, 0, st);
        check("lb_conflict_stall", st, 1);

        // interleaved stores and loads; no store may be lost
        idle(3);
        issue(0, 1, 32'h40, 32'h0BAD_F00D, 3'b010, 0, 0, st);
        issue(1, 0, 32'h50, 0, 3'b010, 0, 0, st);
        issue(0, 1, 32'h44, 32'hCAFE_0001, 3'b010, 0, 0, st);
        issue(1, 0, 32'h54, 0, 3'b101, 0, 0, st);
        issue(0, 1, 32'h48, 32'h0000_77EE, 3'b001, 0, 0, st);
        issue(1, 0, 32'h44, 0, 3'b010, 0, 0, st);

        // fault classification and priority, plus legal boundary accesses
        idle(3);
        issue(1, 0, 32'h03, 0, 3'b001, 0, 1, st);
        issue(1, 0, 32'h80, 0, 3'b010, 0, 1, st);
        issue(1, 0, 32'h7E, 0, 3'b010, 0, 1, st);
        issue(1, 0, 32'h10, 0, 3'b011, 0, 1, st);
        issue(0, 1, 32'h10, 32'h1234_5678, 3'b100, 0, 1, st);
        issue(0, 1, 32'h7F, 32'h1234_5678, 3'b001, 0, 1, st);
        issue(1, 0, 32'h7C, 0, 3'b010, 0, 1, st);
        issue(1, 0, 32'h7F, 0, 3'b100, 0, 1, st);
        issue(0, 1, 32'h7E, 32'h0000_9ABC, 3'b001, 0, 1, st);

        // fence: one buffered store held by a same-cycle load, then drain + 1 cycle
        idle(3);
        issue(0, 1, 32'h60, 32'h5566_7788, 3'b010, 0, 0, st);
        issue(1, 0, 32'h64, 0, 3'b010, 1, 0, st);
        check("flush_cycle_accepted", st, 0);
        n = 0;
        @(negedge clk);
        while (stall && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("flush_stall_cycles", n, 2);
        @(posedge clk); #1;
        issue(1, 0, 32'h60, 0, 3'b010, 0, 0, st);
        check("run_after_flush", st, 0);
        issue(1, 0, 32'h20, 0, 3'b010, 1, 0, st);
        check("flush_empty_nostall", st, 0);

        // reset during the first fence cycle discards the buffered store
        idle(3);
        snap = ref_mem;
        issue(0, 1, 32'h70, 32'hDEAD_BEEF, 3'b010, 0, 0, st);
        issue(1, 0, 32'h74, 0, 3'b010, 1, 0, st);
        rst_n = 1'b0;
        load_q.delete();
        ref_mem = snap;
        @(negedge clk);
        check("reset_mid_flush", {stall, load_valid, exc_valid, load_data, exc_cause, exc_addr, mem_read, mem_write}, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("after_reset_empty", {stall, mem_write}, 0);
        @(posedge clk); #1;

        for (int it = 0; it < 400; it++) begin
            sel = $urandom_range(0, 99);
            if (sel < 8) begin
                idle(1);
                continue;
            end
            rd = ($urandom_range(0, 1) == 1);
            wr = rd ? ($urandom_range(0, 19) == 0) : 1'b1;
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            else if (rd) f3 = ld_f3[$urandom_range(0, 4)];
            else f3 = 3'($urandom_range(0, 2));
            sz  = 1 << f3[1:0];
            sel = $urandom_range(0, 99);
            if (sel < 50)      a = 32'($urandom_range(0, 31));
            else if (sel < 85) a = 32'($urandom_range(0, DB - 1));
            else if (sel < 95) a = 32'($urandom_range(DB - 8, DB + 8));
            else               a = $urandom;
            if ($urandom_range(0, 99) < 85) a = a & ~32'(sz - 1);
            fl = ($urandom_range(0, 24) == 0);
            issue(rd, wr, a, $urandom, f3, fl, 0, st);
        end

        idle(10);
        nmis = 0;
        for (int i = 0; i < DB; i++) if (dmem[i] !== ref_mem[i]) nmis++;
        check("final_mem_mismatches", nmis, 0);
        check("pending_loads", load_q.size(), 0);
        check("pending_excs", exc_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
